// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned FETCH_CNT_W = 32;
  localparam int unsigned FLUSH_CNT_W = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_e;

  // One buffered instruction together with its fetch address
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               IMemReq;
  logic [PC_W-1:0]    IMemAddr;
  logic [INSTR_W-1:0] IMemData;
  logic               Redirect;
  logic [PC_W-1:0]    RedirectPC;
  logic               OutValid;
  logic               OutReady;
  logic [INSTR_W-1:0] OutInstr;
  logic [PC_W-1:0]    OutPC;
  logic [PC_W-1:0]    OutPCPlus4;

  // Fetch stage side
  modport master (
    output IMemReq, IMemAddr, OutValid, OutInstr, OutPC, OutPCPlus4,
    input  IMemData, Redirect, RedirectPC, OutReady
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  IMemReq, IMemAddr, OutValid, OutInstr, OutPC, OutPCPlus4,
    output IMemData, Redirect, RedirectPC, OutReady
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction and its PC while decode stalls.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_unload,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  // Clear wins over load, load wins over unload
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, one-cycle memory, output reg + skid.
// Optional performance counters enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [FETCH_CNT_W-1:0] FetchCount,
  output logic [FLUSH_CNT_W-1:0] FlushCount
`endif
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic            r_pend;
  logic            r_out_valid;
  fetch_entry_t    r_out;
  logic [PC_W-1:0] r_out_pc4;

  logic            w_req;
  logic            w_accept;
  logic            w_load_out;
  logic            w_load_skid;
  logic            w_unload_skid;
  logic            w_skid_valid;
  fetch_entry_t    w_skid_entry;
  fetch_entry_t    w_resp_entry;

  assign w_accept = r_out_valid & bus.OutReady;

  // PC has already advanced past the in-flight request
  assign w_resp_entry = '{instr: bus.IMemData, pc: r_pc - PC_W'(PC_STEP)};

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state, request and buffer steering; redirect overrides everything
  always_comb begin
    w_state_nxt   = r_state;
    w_req         = 1'b0;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_unload_skid = 1'b0;
    case (r_state)
      RUN: begin
        w_req = !(r_out_valid & !bus.OutReady);
        if (r_pend) begin
          if (!r_out_valid || bus.OutReady) begin
            w_load_out = 1'b1;
          end else begin
            w_load_skid = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_accept && w_skid_valid) begin
          w_unload_skid = 1'b1;
          w_state_nxt   = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
    if (bus.Redirect) begin
      w_state_nxt   = RUN;
      w_req         = 1'b0;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_unload_skid = 1'b0;
    end
    if (Reset) w_req = 1'b0;
  end

  // PC, in-flight flag and output register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_pc4   <= '0;
    end else if (bus.Redirect) begin
      r_pc        <= align_pc(bus.RedirectPC);
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_pend <= w_req;
      if (w_req) r_pc <= r_pc + PC_W'(PC_STEP);
      if (w_load_out) begin
        r_out_valid <= 1'b1;
        r_out       <= w_resp_entry;
        r_out_pc4   <= w_resp_entry.pc + PC_W'(PC_STEP);
      end else if (w_unload_skid) begin
        r_out_valid <= 1'b1;
        r_out       <= w_skid_entry;
        r_out_pc4   <= w_skid_entry.pc + PC_W'(PC_STEP);
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  fetch_skid_buf u_skid (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_load   (w_load_skid),
    .i_unload (w_unload_skid),
    .i_clear  (bus.Redirect),
    .i_entry  (w_resp_entry),
    .o_valid  (w_skid_valid),
    .o_entry  (w_skid_entry)
  );

  assign bus.IMemReq    = w_req;
  assign bus.IMemAddr   = r_pc;
  assign bus.OutValid   = r_out_valid;
  assign bus.OutInstr   = r_out.instr;
  assign bus.OutPC      = r_out.pc;
  assign bus.OutPCPlus4 = r_out_pc4;

`ifdef FETCH_PERF_CNT_EN
  logic [FETCH_CNT_W-1:0] r_fetch_cnt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;

  // Accepted-instruction and saturating redirect counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_accept) r_fetch_cnt <= r_fetch_cnt + FETCH_CNT_W'(1);
      if (bus.Redirect && (r_flush_cnt != {FLUSH_CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + FLUSH_CNT_W'(1);
    end
  end

  assign FetchCount = r_fetch_cnt;
  assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage; expected output stream derived
// from "consecutive PCs from reset/redirect target, instr = memory word".
module tb_fetch_stage;

  logic clk;
  logic rst;

  fetch_stage_if ifc0 ();
  fetch_stage_if ifc1 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fc0, fc1;
  logic [15:0] fl0, fl1;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (ifc0)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount (fc0), .FlushCount (fl0)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (ifc1)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount (fc1), .FlushCount (fl1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  int m_fetch;
  int m_flush;
  logic found;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: injective hash of the address, 0x20 holds a NOOP
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'h0;
    return a * 32'd2654435761 + 32'd1;
  endfunction

  // One-cycle read memories
  always @(posedge clk) begin
    ifc0.IMemData <= ifc0.IMemReq ? mem_word(ifc0.IMemAddr) : 32'hDEAD_BEEF;
    ifc1.IMemData <= ifc1.IMemReq ? mem_word(ifc1.IMemAddr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    ifc0.OutReady   = rdy;
    ifc0.Redirect   = redir;
    ifc0.RedirectPC = rpc;
    #1;
  endtask

  // Score the transfer happening at the coming edge, then advance one cycle
  task automatic tick();
    chk("addr_align", {30'b0, ifc0.IMemAddr[1:0]}, 32'h0);
    if (ifc0.OutValid && ifc0.OutReady) begin
      chk("sb_pc", ifc0.OutPC, exp_pc);
      chk("sb_instr", ifc0.OutInstr, mem_word(exp_pc));
      chk("sb_pc4", ifc0.OutPCPlus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      m_fetch++;
    end
    if (ifc0.Redirect) begin
      exp_pc = {ifc0.RedirectPC[31:2], 2'b00};
      m_flush++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc0.OutReady = 1'b1; ifc0.Redirect = 1'b0; ifc0.RedirectPC = 32'h0;
    ifc1.OutReady = 1'b1; ifc1.Redirect = 1'b0; ifc1.RedirectPC = 32'h0;
    exp_pc = 32'h0; m_fetch = 0; m_flush = 0; found = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    chk("rst_valid", 32'(ifc0.OutValid), 32'h0);
    chk("rst_instr", ifc0.OutInstr, 32'h0);
    chk("rst_pc", ifc0.OutPC, 32'h0);
    chk("rst_pc4", ifc0.OutPCPlus4, 32'h0);
    chk("rst_req", 32'(ifc0.IMemReq), 32'h0);
    chk("rst_addr", ifc0.IMemAddr, 32'h0);
    chk("rst_addr1", ifc1.IMemAddr, 32'hFFFF_FFF8);
    chk("rst_req1", 32'(ifc1.IMemReq), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fc", fc0, 32'h0);
    chk("rst_fl", 32'(fl0), 32'h0);
    chk("rst_fc1", fc1 | 32'(fl1), 32'h0);
`endif
    rst = 1'b0;

    // Startup latency and streaming
    drive(1, 0, 0);
    chk("c0_req", 32'(ifc0.IMemReq), 32'h1);
    chk("c0_addr", ifc0.IMemAddr, 32'h0);
    tick();
    drive(1, 0, 0);
    chk("c1_valid", 32'(ifc0.OutValid), 32'h0);
    chk("c1_valid1", 32'(ifc1.OutValid), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("c2_valid", 32'(ifc0.OutValid), 32'h1);
    chk("c2_pc", ifc0.OutPC, 32'h0);
    chk("c2_pc1", ifc1.OutPC, 32'hFFFF_FFF8);
    tick();
    drive(1, 0, 0);
    chk("c3_pc", ifc0.OutPC, 32'h4);
    chk("c3_pc1", ifc1.OutPC, 32'hFFFF_FFFC);
    tick();
    // Stall three cycles with 8 on the output
    drive(0, 0, 0);
    chk("c4_pc", ifc0.OutPC, 32'h8);
    chk("c4_stall_req", 32'(ifc0.IMemReq), 32'h0);
    chk("c4_pc1_wrap", ifc1.OutPC, 32'h0);
    chk("c4_pc4_wrap", ifc1.OutPCPlus4, 32'h4);
    chk("c4_instr1", ifc1.OutInstr, mem_word(32'h0));
    tick();
    drive(0, 0, 0);
    chk("c5_hold_req", 32'(ifc0.IMemReq), 32'h0);
    chk("c5_pc", ifc0.OutPC, 32'h8);
    tick();
    drive(0, 0, 0);
    chk("c6_hold_req", 32'(ifc0.IMemReq), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("c7_hold_req", 32'(ifc0.IMemReq), 32'h0);
    chk("c7_pc", ifc0.OutPC, 32'h8);
    tick();
    drive(1, 0, 0);
    chk("c8_valid", 32'(ifc0.OutValid), 32'h1);
    chk("c8_pc", ifc0.OutPC, 32'hC);
    chk("c8_req", 32'(ifc0.IMemReq), 32'h1);
    chk("c8_addr", ifc0.IMemAddr, 32'h10);
    tick();
    // Stream across the NOOP at 0x20
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0);
      tick();
    end
`ifdef FETCH_PERF_CNT_EN
    drive(1, 0, 0);
    chk("perf_fetch_a", fc0, 32'(m_fetch));
`endif

    // Redirect to 0, then redirect to 0x43 while 0x10 is on the output
    drive(1, 1, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0);
      if (ifc0.OutValid && ifc0.OutPC == 32'h10) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("find_0x10", 32'(found), 32'h1);
    drive(1, 1, 32'h43);
    chk("redir_req", 32'(ifc0.IMemReq), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("redir_next_req", 32'(ifc0.IMemReq), 32'h1);
    chk("redir_next_addr", ifc0.IMemAddr, 32'h40);
    chk("redir_flush_valid", 32'(ifc0.OutValid), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("redir_bubble", 32'(ifc0.OutValid), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("redir_tgt_valid", 32'(ifc0.OutValid), 32'h1);
    chk("redir_tgt_pc", ifc0.OutPC, 32'h40);
    tick();

    // Fill the skid, then redirect from HOLD
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(0, 0, 0);
    tick();
    drive(0, 0, 0);
    chk("hold_req", 32'(ifc0.IMemReq), 32'h0);
    chk("hold_valid", 32'(ifc0.OutValid), 32'h1);
    tick();
    drive(0, 1, 32'h100);
    tick();
    drive(1, 0, 0);
    chk("hredir_req", 32'(ifc0.IMemReq), 32'h1);
    chk("hredir_addr", ifc0.IMemAddr, 32'h100);
    chk("hredir_valid", 32'(ifc0.OutValid), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("hredir_bubble", 32'(ifc0.OutValid), 32'h0);
    tick();
    drive(1, 0, 0);
    chk("hredir_tgt_pc", ifc0.OutPC, 32'h100);
    chk("hredir_tgt_valid", 32'(ifc0.OutValid), 32'h1);
    tick();
`ifdef FETCH_PERF_CNT_EN
    drive(1, 0, 0);
    chk("perf_fetch_b", fc0, 32'(m_fetch));
    chk("perf_flush_b", 32'(fl0), 32'(m_flush));
`endif

    // Random ready / redirect traffic against the stream model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), $urandom);
      tick();
    end
`ifdef FETCH_PERF_CNT_EN
    drive(1, 0, 0);
    chk("perf_fetch_c", fc0, 32'(m_fetch));
    chk("perf_flush_c", 32'(fl0), 32'(m_flush));
`endif

    // Mid-run async reset with both buffers occupied
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(0, 0, 0);
    tick();
    drive(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(ifc0.OutValid), 32'h0);
    chk("mrst_pc", ifc0.OutPC, 32'h0);
    chk("mrst_instr", ifc0.OutInstr, 32'h0);
    chk("mrst_req", 32'(ifc0.IMemReq), 32'h0);
    chk("mrst_addr", ifc0.IMemAddr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mrst_fc", fc0, 32'h0);
    chk("mrst_fl", 32'(fl0), 32'h0);
`endif
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 32'h0; m_fetch = 0; m_flush = 0;
    drive(1, 0, 0);
    chk("mrst_first_req", 32'(ifc0.IMemReq), 32'h1);
    chk("mrst_first_addr", ifc0.IMemAddr, 32'h0);
    tick();
    drive(1, 0, 0);
    tick();
    drive(1, 0, 0);
    chk("mrst_first_out", ifc0.OutPC, 32'h0);
    chk("mrst_first_valid", 32'(ifc0.OutValid), 32'h1);
    tick();
    // Five accepts, then two redirects
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(0, 1, 32'h200);
    tick();
    drive(0, 1, 32'h300);
    tick();
`ifdef FETCH_PERF_CNT_EN
    drive(0, 0, 0);
    chk("perf_fetch_d", fc0, 32'h5);
    chk("perf_flush_d", 32'(fl0), 32'h2);
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
